// File: rtl/lab2_proc_imem_drop_unit.sv
// Fetch-side adapter between F stage and imem: credit-limited request path, response queue,
// and squash handling that discards stale in-flight/buffered instructions.
// Optional macro IMEM_DROP_STATS_EN adds a 32-bit drop_count statistics output.
module lab2_proc_imem_drop_unit #(
  parameter int p_num_entries = 2,
  parameter int p_data_nbits  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [31:0]             req_addr,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic [p_data_nbits-1:0] resp_data,
  input  logic                    squash
`ifdef IMEM_DROP_STATS_EN
  ,
  output logic [31:0]             drop_count
`endif
);

  localparam int CW = $clog2(p_num_entries) + 1;
  localparam int PW = $clog2(p_num_entries);

  logic [CW-1:0]           inflight, inflight_n;
  logic [CW-1:0]           drop_cnt, drop_cnt_n;
  logic [CW-1:0]           count, count_n;
  logic [PW-1:0]           head, head_n;
  logic [PW-1:0]           tail, tail_n;
  logic [p_data_nbits-1:0] entries [p_num_entries];

  logic [CW:0] occupancy;
  logic        credit;
  logic        req_fire;
  logic        resp_fire;
  logic        dropping;
  logic        drop_now;
  logic        enq;
  logic        deq;

  // Credit covers both queued entries and outstanding requests, so a
  // response always has a slot waiting for it even if it will be dropped.
  assign occupancy    = {1'b0, inflight} + {1'b0, count};
  assign credit       = occupancy < (CW+1)'(p_num_entries);

  assign mem_req_val  = req_val & credit & ~reset;
  assign req_rdy      = mem_req_rdy & credit;
  assign mem_req_addr = req_addr;
  assign req_fire     = req_val & req_rdy;

  assign dropping     = (drop_cnt != '0);
  assign mem_resp_rdy = squash | dropping | (count < CW'(p_num_entries));
  assign resp_fire    = mem_resp_val & mem_resp_rdy;
  assign drop_now     = resp_fire & (squash | dropping);
  assign enq          = resp_fire & ~squash & ~dropping;

  assign resp_val     = (count != '0) & ~squash & ~reset;
  assign resp_data    = entries[head];
  assign deq          = resp_val & resp_rdy;

  always_comb begin
    inflight_n = inflight + CW'(req_fire) - CW'(resp_fire);
    drop_cnt_n = drop_cnt;
    count_n    = count;
    head_n     = head;
    tail_n     = tail;
    if (squash) begin
      // Everything issued before this cycle is stale, minus a response landing now.
      drop_cnt_n = inflight - CW'(resp_fire);
      count_n    = '0;
      head_n     = tail;
    end else begin
      drop_cnt_n = drop_cnt - CW'(resp_fire & dropping);
      count_n    = count + CW'(enq) - CW'(deq);
      head_n     = head + PW'(deq);
      tail_n     = tail + PW'(enq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight_n;
      drop_cnt <= drop_cnt_n;
      count    <= count_n;
      head     <= head_n;
      tail     <= tail_n;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= mem_resp_data;
  end

`ifdef IMEM_DROP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else       drop_count <= drop_count + 32'(drop_now) + (squash ? 32'(count) : 32'd0);
  end
`else
  logic unused_drop_now;
  assign unused_drop_now = drop_now;
`endif

  a_drop_le_inflight: assert property (@(posedge clk) disable iff (reset) drop_cnt <= inflight);
  a_occupancy_bound:  assert property (@(posedge clk) disable iff (reset)
                                       occupancy <= (CW+1)'(p_num_entries));
  a_no_overflow_enq:  assert property (@(posedge clk) disable iff (reset)
                                       (enq && count == CW'(p_num_entries)) |-> deq);

endmodule
